// File: rtl/codec_init_pkg.sv
// -----------------------------------------------------------------------------
// codec_init_pkg
// Shared definitions for the audio codec power-up sequencer:
//   - state_t        : sequencer FSM state encoding
//   - CODEC_DEV_ADDR : 8-bit I2C write address of the codec (8'h34)
//   - INIT_TABLE     : register write table, {7-bit reg addr, 9-bit value}.
//                      Entry 0 is the codec soft reset and entry 9 is the
//                      activate write. Slots 10..15 pad the table so that
//                      any 4-bit index is a legal lookup.
//   - MAX_RETRIES    : retries per entry when CODEC_INIT_RETRY_EN is defined
// -----------------------------------------------------------------------------
package codec_init_pkg;

   typedef enum logic [2:0] {
      S_DELAY    = 3'd0,
      S_LOAD     = 3'd1,
      S_REQ      = 3'd2,
      S_WAIT_ACK = 3'd3,
      S_GAP      = 3'd4,
      S_DONE     = 3'd5,
      S_FAIL     = 3'd6
   } state_t;

   localparam logic [7:0] CODEC_DEV_ADDR = 8'h34;

   localparam int INIT_TABLE_LEN = 10;
   localparam int MAX_RETRIES    = 3;

   localparam logic [15:0] INIT_TABLE [16] = '{
      16'h1E00,   // R15 reset
      16'h0017,   // R0  left line in
      16'h0217,   // R1  right line in
      16'h0479,   // R2  left headphone out
      16'h0679,   // R3  right headphone out
      16'h0812,   // R4  analogue path
      16'h0A00,   // R5  digital path
      16'h0C00,   // R6  power down control: all on
      16'h0E42,   // R7  interface format: master, I2S, 16 bit
      16'h1201,   // R9  activate
      16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000
   };

endpackage

// File: rtl/codec_reg_rom.sv
// -----------------------------------------------------------------------------
// codec_reg_rom
// Combinational lookup of one init-table entry.
// Ports:
//   idx   in  4   table index
//   entry out 16  {7-bit register address, 9-bit value}
// -----------------------------------------------------------------------------
module codec_reg_rom
   import codec_init_pkg::*;
(
   input  logic [3:0]  idx,
   output logic [15:0] entry
);

   always_comb begin
      entry = INIT_TABLE[idx];
   end

endmodule

// File: rtl/codec_init_ctrl.sv
// -----------------------------------------------------------------------------
// codec_init_ctrl
// Power-up sequencer for an I2C audio codec. After reset it idles for
// INIT_DELAY cycles, then writes REG_NUM table entries one at a time through
// a request/ack handshake with an external I2C master.
//
// Ports:
//   clk        in   1   system clock
//   rst        in   1   asynchronous active-high reset
//   reinit     in   1   restart pulse, honoured only when done or failed
//   i2c_req    out  1   write request, held until i2c_ack
//   i2c_dev    out  8   codec write address (constant 8'h34)
//   i2c_data   out  16  {reg addr, value}, stable while i2c_req is high
//   i2c_ack    in   1   one-cycle transaction-finished pulse
//   i2c_err    in   1   NACK flag, qualified by i2c_ack
//   reg_index  out  4   current table entry
//   init_done  out  1   all entries written
//   init_fail  out  1   sequence aborted (NACK or ack timeout)
//
// Build option:
//   CODEC_INIT_RETRY_EN  when defined, an errored entry is reissued up to
//                        MAX_RETRIES times before the sequence aborts.
// -----------------------------------------------------------------------------
module codec_init_ctrl
   import codec_init_pkg::*;
#(
   parameter int INIT_DELAY     = 50000,
   parameter int REG_NUM        = 10,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int GAP_CYCLES     = 2
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        reinit,
   output logic        i2c_req,
   output logic [7:0]  i2c_dev,
   output logic [15:0] i2c_data,
   input  logic        i2c_ack,
   input  logic        i2c_err,
   output logic [3:0]  reg_index,
   output logic        init_done,
   output logic        init_fail
);

   localparam int DW = $clog2(INIT_DELAY + 2);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
   localparam int GW = $clog2(GAP_CYCLES + 2);

   localparam logic [DW-1:0] DELAY_LAST = DW'(INIT_DELAY - 1);
   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [3:0]    LAST_IDX   = 4'(REG_NUM - 1);

   state_t          state;
   state_t          next_state;
   logic [DW-1:0]   delay_cnt;
   logic [TW-1:0]   to_cnt;
   logic [GW-1:0]   gap_cnt;
   logic [15:0]     rom_entry;
   logic            in_xfer;
   logic            xfer_ok;
   logic            xfer_err;
   logic            retry_ok;
   logic            retry_gap;   // current GAP reissues the same entry
   logic            restart;

   assign i2c_dev = CODEC_DEV_ADDR;

   codec_reg_rom u_rom (
      .idx   (reg_index),
      .entry (rom_entry)
   );

   assign in_xfer  = (state == S_REQ) || (state == S_WAIT_ACK);
   assign xfer_ok  = in_xfer && i2c_ack && !i2c_err;
   // A missing ack after TIMEOUT_CYCLES of request is handled as a NACK;
   // an ack in the final cycle still wins.
   assign xfer_err = in_xfer && ((i2c_ack && i2c_err) || (!i2c_ack && (to_cnt == TO_LAST)));
   assign restart  = ((state == S_DONE) || (state == S_FAIL)) && reinit;

`ifdef CODEC_INIT_RETRY_EN
   logic [1:0] retry_cnt;

   assign retry_ok = (retry_cnt < 2'(MAX_RETRIES));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retry_cnt <= 2'd0;
      end else if (xfer_ok || restart) begin
         retry_cnt <= 2'd0;
      end else if (xfer_err && retry_ok) begin
         retry_cnt <= retry_cnt + 2'd1;
      end
   end
`else
   assign retry_ok = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_DELAY;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_DELAY:    if (delay_cnt == DELAY_LAST) next_state = S_LOAD;
         S_LOAD:     next_state = S_REQ;
         S_REQ,
         S_WAIT_ACK: begin
            if (xfer_ok)       next_state = (reg_index == LAST_IDX) ? S_DONE : S_GAP;
            else if (xfer_err) next_state = retry_ok ? S_GAP : S_FAIL;
            else               next_state = S_WAIT_ACK;
         end
         S_GAP:      if (gap_cnt == GAP_LAST) next_state = S_LOAD;
         S_DONE,
         S_FAIL:     if (reinit) next_state = S_LOAD;
         default:    next_state = S_DELAY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         delay_cnt <= '0;
         to_cnt    <= '0;
         gap_cnt   <= '0;
         i2c_req   <= 1'b0;
         i2c_data  <= 16'h0000;
         reg_index <= 4'd0;
         init_done <= 1'b0;
         init_fail <= 1'b0;
         retry_gap <= 1'b0;
      end else begin
         delay_cnt <= (state == S_DELAY) ? delay_cnt + DW'(1) : '0;
         to_cnt    <= in_xfer ? to_cnt + TW'(1) : '0;
         gap_cnt   <= (state == S_GAP) ? gap_cnt + GW'(1) : '0;
         // Request mirrors the transfer states, so it falls right after the ack.
         i2c_req   <= (next_state == S_REQ) || (next_state == S_WAIT_ACK);
         init_done <= (next_state == S_DONE);
         init_fail <= (next_state == S_FAIL);

         if (state == S_LOAD) i2c_data <= rom_entry;

         if (xfer_ok || xfer_err) retry_gap <= xfer_err;

         if ((state == S_GAP) && (gap_cnt == GAP_LAST) && !retry_gap)
            reg_index <= reg_index + 4'd1;
         else if (restart)
            reg_index <= 4'd0;
      end
   end

endmodule
